// File: rtl/aes_input_loader_pkg.sv
// aes_input_loader_pkg
//   Constants shared by the AES byte loader, key expansion and cipher control:
//   block type codes, block size in bytes, and the loader's FSM states.
package aes_input_loader_pkg;

  localparam logic [1:0] TYPE_KEY    = 2'b10;
  localparam logic [1:0] TYPE_DATA   = 2'b01;
  localparam int         BLOCK_BYTES = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

  // 2'b00 and 2'b11 carry no meaning; bytes tagged with them are dropped.
  function automatic logic is_reserved(input logic [1:0] t);
    return (t != TYPE_KEY) && (t != TYPE_DATA);
  endfunction

endpackage

// File: rtl/aes_input_loader.sv
// aes_input_loader
//   Byte-serial front end of the AES core. Collects 16 typed bytes into a
//   128-bit block (first byte in [7:0]) and presents it with its type as a
//   single-cycle out_valid pulse, stalled by out_hold.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_type   byte input handshake
//   out_hold       downstream backpressure (only meaningful while emitting)
//   out_valid/out_type/out_data         assembled block
//   err            one-cycle pulse after a type mismatch or reserved type
import aes_input_loader_pkg::*;

module aes_input_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic [1:0]   in_type,
  input  logic         out_hold,
  output logic         out_valid,
  output logic [1:0]   out_type,
  output logic [127:0] out_data,
  output logic         err
);

  state_e       r_state, w_state_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_buf;
  logic [1:0]   r_type;
  logic         r_err;

  logic w_accept, w_rsvd, w_mismatch, w_last;

  assign w_accept   = in_valid && (r_state == ST_COLLECT);
  assign w_rsvd     = is_reserved(in_type);
  // Reserved type outranks mismatch, so mismatch is only a legal-type event.
  assign w_mismatch = !w_rsvd && (r_cnt != 4'd0) && (in_type != r_type);
  assign w_last     = (r_cnt == 4'(BLOCK_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_COLLECT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (w_accept && !w_rsvd && !w_mismatch && w_last) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = !out_hold;
        if (!out_hold) w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // Datapath: byte-lane write decoder, type latch, count and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 4'd0;
      r_buf  <= '0;
      r_type <= 2'b00;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_rsvd) begin
          r_cnt <= 4'd0;
          r_err <= 1'b1;
        end else if (w_mismatch) begin
          // Offending byte restarts the block as its byte 0.
          r_buf[7:0] <= in_data;
          r_type     <= in_type;
          r_cnt      <= 4'd1;
          r_err      <= 1'b1;
        end else begin
          r_buf[{r_cnt, 3'b000} +: 8] <= in_data;
          if (r_cnt == 4'd0) r_type <= in_type;
          r_cnt <= r_cnt + 4'd1;  // wraps to 0 after byte 15
        end
      end
    end
  end

  assign out_type = r_type;
  assign out_data = r_buf;
  assign err      = r_err;

endmodule
